// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side definitions: datapath width, canonical NOP, queue entry layout
// and the word-align helper used wherever an address enters the fetch path.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    // One buffered fetch: the byte address it was read from and the word returned.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    // Byte addresses into the instruction ROM are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the ROM read port and the IF/IF_ID handoff signals of the prefetch queue.
// master = the queue itself, slave = the ROM / pipeline side around it.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     imem_req;
    logic [31:0]              imem_addr;
    logic [31:0]              imem_rdata;
    logic                     IFWrite;
    logic                     Redirect;
    logic [31:0]              JumpAddr;
    logic [31:0]              Instruction_if;
    logic [31:0]              PC;
    logic                     valid_if;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output imem_req, imem_addr, Instruction_if, PC, valid_if, count,
        input  imem_rdata, IFWrite, Redirect, JumpAddr
    );

    modport slave (
        input  imem_req, imem_addr, Instruction_if, PC, valid_if, count,
        output imem_rdata, IFWrite, Redirect, JumpAddr
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Small synchronous FIFO of {PC, instruction} entries with flush.
// The head entry is read combinationally so IF sees it in the same cycle it lands.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_entry,
    output fetch_entry_t           head_entry,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   head_ptr;
    logic [AW-1:0]   tail_ptr;
    logic            do_push;
    logic            do_pop;

    // A pop on an empty queue is ignored; flush and reset override both.
    assign do_push    = push && !flush && !reset;
    assign do_pop     = pop && head_valid;
    assign head_valid = (count != '0);
    assign head_entry = mem[head_ptr];

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail_ptr] <= wr_entry;
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + AW'(1);
            if (do_pop)  head_ptr <= head_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue throttling must keep the queue from ever overflowing.
    always_ff @(posedge clk) begin
        if (!reset) assert (count <= FULL);
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: runs sequential ROM reads ahead of decode, buffers
// the results, and restarts cleanly at the target on a Jump/Branch redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = RV_NOP
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_addr;
    logic          inflight;
    logic          issue;
    logic          push;
    logic [CW-1:0] fifo_count;
    logic          head_valid;
    fetch_entry_t  head_entry;
    fetch_entry_t  wr_entry;

    // A read is only issued if its data is guaranteed a free slot when it returns.
    assign issue = !reset && !bus.Redirect &&
                   ((fifo_count + CW'(inflight)) < CW'(DEPTH));

    // Data returning in a redirect cycle belongs to the old path and is dropped.
    assign push     = inflight && !bus.Redirect;
    assign wr_entry = '{pc: inflight_addr, insn: bus.imem_rdata};

    // Next sequential fetch address, reloaded on reset or redirect.
    always_ff @(posedge clk) begin
        if (reset)             fetch_pc <= RESET_PC;
        else if (bus.Redirect) fetch_pc <= word_align(bus.JumpAddr);
        else if (issue)        fetch_pc <= fetch_pc + 32'd4;
    end

    // Track the single outstanding ROM read and the address it was issued to.
    always_ff @(posedge clk) begin
        if (reset) inflight <= 1'b0;
        else       inflight <= issue;
        inflight_addr <= fetch_pc;
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (bus.IFWrite),
        .flush      (bus.Redirect),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign bus.imem_req       = issue;
    assign bus.imem_addr      = fetch_pc;
    assign bus.valid_if       = head_valid;
    assign bus.Instruction_if = head_valid ? head_entry.insn : NOP_INSN;
    assign bus.PC             = head_valid ? head_entry.pc : 32'h0000_0000;
    assign bus.count          = fifo_count;

endmodule
